// File: rtl/logit_search.sv
// Inverse sigmoid: a fixed 9-step binary search over the sigmoid table returns the smallest x with lut(x) >= p.
// Optional LOGIT_SAT_FLAG_EN adds out_sat, which flags codes outside the table's reachable range.
module logit_search #(
  parameter int N        = 2,
  parameter int QM       = 6,
  parameter int QN       = 10,
  parameter int LUT_BITS = 8,
  parameter int LUT_QN   = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_p,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [QM+QN+N-1:0]   out_x
`ifdef LOGIT_SAT_FLAG_EN
  ,
  output logic                 out_sat
`endif
);

  localparam int W        = QM + QN + N;
  localparam int IW       = LUT_BITS + 2;
  localparam int SHIFT    = QN - LUT_QN;
  localparam int STEPS    = LUT_BITS + 1;
  localparam int LUT_HALF = 2 ** (LUT_BITS - 1);

  localparam logic signed [IW-1:0] IDX_MIN = IW'(-LUT_HALF);
  localparam logic signed [IW-1:0] IDX_MAX = IW'(LUT_HALF);

  // The sigmoid table is monotone from 0 to 31, so it is stored as the first
  // index at which each code k = 1..31 is reached: ceil(32 * ln(k / (32 - k))).
  // These values hold for LUT_QN = 5 and LUT_BITS = 8.
  localparam int THRESH [31] = '{
    -109, -86, -72, -62, -53, -46, -40, -35, -30, -25, -20, -16, -12, -8, -4, 0,
       5,   9,  13,  17,  21,  26,  31,  36,  41,  47,  54,  63,  73, 87, 110
  };

  function automatic logic [7:0] lut_val(input logic signed [IW-1:0] idx);
    logic [7:0] v;
    v = '0;
    for (int k = 0; k < 31; k++) begin
      if (int'(idx) >= THRESH[k]) v = v + 8'd1;
    end
    return v;
  endfunction

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t                state, state_nxt;
  logic signed [IW-1:0]  lo, hi, mid, lo_nxt, hi_nxt;
  logic [7:0]            p;
  logic [3:0]            cnt;
  logic                  last_step;
  logic [W-1:0]          x_scaled;

  assign last_step = (cnt == 4'(STEPS - 1));

  // One search step; once the interval has collapsed further steps change nothing.
  always_comb begin
    mid    = (lo + hi) >>> 1;
    lo_nxt = lo;
    hi_nxt = hi;
    if (lo < hi) begin
      if (lut_val(mid) >= p) hi_nxt = mid;
      else                   lo_nxt = mid + 10'sd1;
    end
    x_scaled = {{(W-IW){lo_nxt[IW-1]}}, lo_nxt} << SHIFT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = SEARCH;
      SEARCH:  if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo    <= '0;
      hi    <= '0;
      cnt   <= '0;
      p     <= '0;
      out_x <= '0;
`ifdef LOGIT_SAT_FLAG_EN
      out_sat <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            p   <= in_p;
            lo  <= IDX_MIN;
            hi  <= IDX_MAX;
            cnt <= '0;
          end
        end
        SEARCH: begin
          lo  <= lo_nxt;
          hi  <= hi_nxt;
          cnt <= cnt + 4'd1;
          if (last_step) begin
            out_x <= x_scaled;
`ifdef LOGIT_SAT_FLAG_EN
            out_sat <= (lo_nxt == IDX_MIN) || (p > lut_val(IDX_MAX));
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/logit_search.md
Name: logit_search

Overview:
- Inverse of the fixed-point sigmoid activation: takes a probability code and returns the pre-activation value x whose sigmoid first reaches that code.
- Used by the training and calibration path to map target probabilities back into the neuron accumulator domain.
- Performs a sequential binary search over an internal copy of the 257-entry sigmoid table, with valid/ready handshakes on input and output.

Parameters:
- N, 2, extra integer guard bits of the accumulator format
- QM, 6, integer bits of the accumulator format
- QN, 10, fractional bits of the accumulator format
- LUT_BITS, 8, table index width; index range is -2^(LUT_BITS-1)..+2^(LUT_BITS-1)
- LUT_QN, 5, fractional bits of the table index and of the probability code

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  probability code available
- in_ready  out  1  block can accept a code
- in_p  in  8  unsigned probability code, units of 2^-LUT_QN
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_x  out  QM+QN+N  signed result in accumulator format (Q(QM+N).QN)

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Table definition: lut(i) = floor((1/(1+exp(-i*2^-LUT_QN))) * 2^LUT_QN), truncated to 8 bits, for i = -128..+128.
  - The table is constant and fixed at elaboration.
  - Key entries: lut(0)=16, lut(128)=31, lut(-128)=0.
- Result index: R = smallest i in [-128,128] with lut(i) >= in_p. If no such i exists (in_p > 31), R = +128.
- out_x = sign-extend(R) << (QN-LUT_QN), registered.
- FSM states: IDLE, SEARCH, DONE.
  - IDLE: in_ready=1. On in_valid: latch in_p, set lo=-128, hi=+128, step counter=0, go to SEARCH.
  - SEARCH: one step per clock.
    - mid = (lo+hi) >>> 1, computed with a 10-bit signed sum and arithmetic shift (floor).
    - If lut(mid) >= p then hi=mid, else lo=mid+1.
    - Exactly 9 steps are always executed (ceil(log2 257)); steps taken after lo==hi are no-ops. This gives fixed latency.
    - After the 9th step: out_x <= lo scaled, go to DONE.
  - DONE: out_valid=1; out_x is held stable. On out_ready: go to IDLE, out_valid=0.
- Latency: in_p accepted on edge T; out_valid rises after edge T+9. Minimum interval between accepts is 11 cycles.
- in_ready=0 in SEARCH and DONE. in_valid is ignored there; in_p changes are ignored after capture.
- An out_ready asserted while not in DONE has no effect.
- Reset values: in_ready=1 (state IDLE), out_valid=0, out_x=0, lo=hi=0, counter=0.
- Reset asserted mid-SEARCH or in DONE aborts immediately. No result is emitted and the block returns to IDLE.
- Codes 32..255 all yield R=+128. Code 0 yields R=-128.

Optional Feature:
- Macro: LOGIT_SAT_FLAG_EN.
- Defined:
  - Adds output port out_sat (1 bit), registered together with out_x and valid only while out_valid=1.
  - out_sat=1 when R=-128 (in_p=0) or when no table entry satisfies the compare (in_p > lut(128)); otherwise 0.
  - Reset value 0.
- Undefined: the port does not exist and no saturation detection logic is built. out_x behaviour is identical in both builds.

Test Plan:
- in_p=16 -> out_x=0 (R=0); out_valid exactly 9 cycles after accept; out_sat=0.
- in_p=24 -> out_x=1152 (R=36). in_p=8 -> out_x=-1120 (R=-35).
- in_p=31 -> out_x=3520 (R=110). in_p=32 and in_p=255 -> out_x=4096 with out_sat=1. in_p=0 -> out_x=-4096 with out_sat=1.
- Backpressure: hold out_ready=0 for 20 cycles -> out_valid and out_x stable, in_ready=0, a new in_valid is ignored. Release -> IDLE next cycle, then the new code is accepted.
- Pulse rst_n low at SEARCH step 4 -> out_valid=0 and out_x=0 immediately; in_ready=1 after release. The next request returns a correct result.
- Sweep in_p=0..40 back-to-back, checking each result against the table definition computed in the bench model.
